// File: rtl/cart_sdram_arbiter_if.sv
// Bundle of the download, cartridge-read and SDRAM-port signals around cart_sdram_arbiter.
// The arbiter uses the slave view; the surrounding system (or a bench) uses the master view.
interface cart_sdram_arbiter_if #(
    parameter int ADDR_W = 25
);
    logic              dl_active;
    logic              dl_wr;
    logic [ADDR_W-1:0] dl_addr;
    logic [7:0]        dl_data;
    logic              dl_overflow;
    logic              dl_idle;

    logic              cart_rd;
    logic [19:0]       cart_a;
    logic [7:0]        cart_d;
    logic              cart_valid;

    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;
    logic              mem_ack;
    logic [7:0]        mem_rdata;

    modport slave (
        input  dl_active, dl_wr, dl_addr, dl_data, cart_rd, cart_a, mem_ack, mem_rdata,
        output dl_overflow, dl_idle, cart_d, cart_valid, mem_req, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output dl_active, dl_wr, dl_addr, dl_data, cart_rd, cart_a, mem_ack, mem_rdata,
        input  dl_overflow, dl_idle, cart_d, cart_valid, mem_req, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/cart_sdram_arbiter.sv
// Shares one SDRAM port between buffered ioctl download writes and console cartridge reads.
//
// state    | meaning
// ---------+-----------------------------------------------------------------
// ST_IDLE  | no request outstanding; picks read, write or nothing each cycle
// ST_WRITE | FIFO head presented to SDRAM, waiting for mem_ack
// ST_READ  | cartridge read presented to SDRAM, waiting for mem_ack
module cart_sdram_arbiter #(
    parameter int FIFO_DEPTH   = 8,
    parameter int MAX_WR_BURST = 4,
    parameter int ADDR_W       = 25
) (
    input  logic                clk_sys,
    input  logic                reset,
    cart_sdram_arbiter_if.slave bus
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int BC_W  = $clog2(MAX_WR_BURST + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_READ  = 2'd2
    } state_t;

    state_t state, state_nxt;
    logic   do_read, do_write;

    logic [ADDR_W+7:0] fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [CNT_W-1:0]  fifo_cnt;
    logic              fifo_empty, fifo_full, push;
    logic [ADDR_W+7:0] head;

    logic [BC_W-1:0]   burst_cnt;
    logic              rd_pend;
    logic [ADDR_W-1:0] rd_addr;
    logic [ADDR_W-1:0] cart_a_ext;
    logic              dl_active_q;

    logic              mem_we_r;
    logic [ADDR_W-1:0] mem_addr_r;
    logic [7:0]        mem_wdata_r;
    logic [7:0]        cart_d_r;
    logic              cart_valid_r;
    logic              overflow_r;

    assign fifo_empty = (fifo_cnt == '0);
    assign fifo_full  = (fifo_cnt == CNT_W'(FIFO_DEPTH));
    assign push       = bus.dl_wr && !fifo_full;
    assign head       = fifo_mem[rd_ptr];
    assign cart_a_ext = ADDR_W'(bus.cart_a);

    always_comb begin
        state_nxt = state;
        do_read   = 1'b0;
        do_write  = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (rd_pend && (fifo_empty || burst_cnt == BC_W'(MAX_WR_BURST))) begin
                    do_read   = 1'b1;
                    state_nxt = ST_READ;
                end else if (!fifo_empty) begin
                    do_write  = 1'b1;
                    state_nxt = ST_WRITE;
                end
            end
            ST_WRITE, ST_READ: begin
                if (bus.mem_ack) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (push) fifo_mem[wr_ptr] <= {bus.dl_addr, bus.dl_data};
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push)     wr_ptr <= wr_ptr + 1'b1;
            if (do_write) rd_ptr <= rd_ptr + 1'b1;
            case ({push, do_write})
                2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
                2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state        <= ST_IDLE;
            burst_cnt    <= '0;
            rd_pend      <= 1'b0;
            rd_addr      <= '0;
            mem_we_r     <= 1'b0;
            mem_addr_r   <= '0;
            mem_wdata_r  <= '0;
            cart_d_r     <= '0;
            cart_valid_r <= 1'b0;
            overflow_r   <= 1'b0;
            dl_active_q  <= 1'b0;
        end else begin
            state        <= state_nxt;
            cart_valid_r <= 1'b0;
            dl_active_q  <= bus.dl_active;

            // A strobe arriving on the issue cycle is folded into this read (latest wins).
            if (do_read) begin
                burst_cnt   <= '0;
                rd_pend     <= 1'b0;
                mem_we_r    <= 1'b0;
                mem_addr_r  <= bus.cart_rd ? cart_a_ext : rd_addr;
                mem_wdata_r <= '0;
            end else begin
                if (bus.cart_rd) begin
                    rd_pend <= 1'b1;
                    rd_addr <= cart_a_ext;
                end
                if (do_write) begin
                    mem_we_r    <= 1'b1;
                    mem_addr_r  <= head[ADDR_W+7:8];
                    mem_wdata_r <= head[7:0];
                    if (burst_cnt != BC_W'(MAX_WR_BURST)) burst_cnt <= burst_cnt + 1'b1;
                end else if (state == ST_IDLE && !rd_pend) begin
                    burst_cnt <= '0;
                end
            end

            if (state == ST_READ && bus.mem_ack) begin
                cart_d_r     <= bus.mem_rdata;
                cart_valid_r <= 1'b1;
            end

            if (bus.dl_wr && fifo_full)
                overflow_r <= 1'b1;
            else if (bus.dl_active && !dl_active_q)
                overflow_r <= 1'b0;
        end
    end

    assign bus.mem_req     = (state == ST_WRITE) || (state == ST_READ);
    assign bus.mem_we      = mem_we_r;
    assign bus.mem_addr    = mem_addr_r;
    assign bus.mem_wdata   = mem_wdata_r;
    assign bus.cart_d      = cart_d_r;
    assign bus.cart_valid  = cart_valid_r;
    assign bus.dl_overflow = overflow_r;
    assign bus.dl_idle     = fifo_empty && (state != ST_WRITE);
endmodule

// File: tb/tb_cart_sdram_arbiter.sv
// Bench for cart_sdram_arbiter: SDRAM responder, queue-based reference model and a
// negedge monitor that scores every issued request and every returned read byte.
module tb_cart_sdram_arbiter;
    localparam int FIFO_DEPTH   = 8;
    localparam int MAX_WR_BURST = 4;
    localparam int ADDR_W       = 25;

    logic clk_sys = 1'b0;
    logic reset;
    always #5 clk_sys = ~clk_sys;

    cart_sdram_arbiter_if #(.ADDR_W(ADDR_W)) bus ();

    cart_sdram_arbiter #(
        .FIFO_DEPTH  (FIFO_DEPTH),
        .MAX_WR_BURST(MAX_WR_BURST),
        .ADDR_W      (ADDR_W)
    ) dut (
        .clk_sys(clk_sys),
        .reset  (reset),
        .bus    (bus)
    );

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [7:0]        data;
    } op_t;

    int vectors     = 0;
    int miscompares = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // reference model state (written only by the monitor)
    op_t               wq[$];
    op_t               log_q[$];
    logic [7:0]        rdq[$];
    bit                m_ovf, m_rd_pend, m_wr_fly;
    logic [ADDR_W-1:0] m_rd_addr;
    int                wr_while_pend;
    bit                prev_req, prev_ack, prev_ack_rd, prev_active;
    op_t               cur, exp_op;

    // responder controls (written only by the main process)
    bit auto_ack     = 1'b1;
    bit late_ack_req = 1'b0;
    int lat_min      = 1;
    int lat_max      = 1;
    int force_rdata  = -1;
    bit late_ack_done = 1'b0;

    initial begin
        bit busy;
        int wcnt, lat;
        busy = 1'b0; wcnt = 0; lat = 0;
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = 8'h00;
        forever begin
            @(posedge clk_sys); #1;
            if (bus.mem_ack) begin
                bus.mem_ack = 1'b0;
            end else if (late_ack_req && !late_ack_done) begin
                bus.mem_ack   = 1'b1;
                bus.mem_rdata = 8'h3C;
                late_ack_done = 1'b1;
            end else if (auto_ack && bus.mem_req) begin
                if (!busy) begin
                    busy = 1'b1;
                    wcnt = 0;
                    lat  = int'($urandom_range(lat_max, lat_min));
                end
                if (wcnt >= lat) begin
                    bus.mem_ack   = 1'b1;
                    bus.mem_rdata = (force_rdata >= 0) ? 8'(force_rdata) : 8'($urandom);
                    busy = 1'b0;
                end else begin
                    wcnt++;
                end
            end
        end
    end

    always @(negedge clk_sys) begin
        if (reset) begin
            wq.delete();
            rdq.delete();
            m_ovf = 0; m_rd_pend = 0; m_wr_fly = 0; wr_while_pend = 0;
            prev_req = 0; prev_ack = 0; prev_ack_rd = 0;
            prev_active = bus.dl_active;
        end else begin
            chk("cart_valid", bus.cart_valid, prev_ack_rd);
            if (bus.cart_valid) begin
                chk("rd_resp_queued", rdq.size() > 0, 1);
                if (rdq.size() > 0) chk("cart_d", bus.cart_d, rdq.pop_front());
            end
            if (prev_req && !prev_ack) begin
                chk("mem_req_held", bus.mem_req, 1);
                if (bus.mem_req) chk("mem_stable", {bus.mem_we, bus.mem_addr, bus.mem_wdata}, cur);
            end
            if (bus.mem_req && !prev_req) begin
                cur = '{we: bus.mem_we, addr: bus.mem_addr, data: bus.mem_wdata};
                log_q.push_back(cur);
                if (bus.mem_we) begin
                    chk("wr_expected", wq.size() > 0, 1);
                    if (wq.size() > 0) begin
                        exp_op = wq.pop_front();
                        chk("wr_addr", bus.mem_addr, exp_op.addr);
                        chk("wr_data", bus.mem_wdata, exp_op.data);
                    end
                    m_wr_fly = 1;
                    if (m_rd_pend) begin
                        wr_while_pend++;
                        chk("burst_limit", wr_while_pend <= MAX_WR_BURST, 1);
                    end
                end else begin
                    chk("rd_pending", m_rd_pend, 1);
                    chk("rd_addr", bus.mem_addr, m_rd_addr);
                    m_rd_pend = 0;
                    wr_while_pend = 0;
                end
            end
            chk("dl_overflow", bus.dl_overflow, m_ovf);
            chk("dl_idle", bus.dl_idle, (wq.size() == 0) && !m_wr_fly);
            if (bus.mem_req && bus.mem_ack) begin
                if (bus.mem_we) m_wr_fly = 0;
                else rdq.push_back(bus.mem_rdata);
            end
            prev_ack_rd = bus.mem_req && bus.mem_ack && !bus.mem_we;
            prev_ack    = bus.mem_req && bus.mem_ack;
            prev_req    = bus.mem_req;
            if (bus.dl_wr && wq.size() >= FIFO_DEPTH)
                m_ovf = 1;
            else if (bus.dl_active && !prev_active)
                m_ovf = 0;
            if (bus.dl_wr && wq.size() < FIFO_DEPTH)
                wq.push_back('{we: 1'b1, addr: bus.dl_addr, data: bus.dl_data});
            prev_active = bus.dl_active;
            if (bus.cart_rd) begin
                m_rd_pend = 1;
                m_rd_addr = ADDR_W'(bus.cart_a);
            end
        end
    end

    task automatic cyc();
        @(posedge clk_sys); #1;
    endtask

    task automatic drain(input string name, input int budget);
        int n = 0;
        bus.dl_wr = 0; bus.cart_rd = 0;
        cyc();
        while (!(bus.dl_idle && !bus.mem_req && !m_rd_pend && rdq.size() == 0 && !bus.cart_valid)
               && n < budget) begin
            cyc();
            n++;
        end
        chk({name, "_drain_timeout"}, n < budget, 1);
    endtask

    task automatic wr_strobe(input logic [ADDR_W-1:0] a, input logic [7:0] d);
        bus.dl_wr = 1; bus.dl_addr = a; bus.dl_data = d;
        cyc();
        bus.dl_wr = 0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [ADDR_W-1:0] t_addr [8];
        logic [7:0]        t_data [8];
        logic [8:0]        seq;
        int base;
        op_t o;

        reset = 1;
        bus.dl_active = 0; bus.dl_wr = 0; bus.dl_addr = '0; bus.dl_data = '0;
        bus.cart_rd = 0; bus.cart_a = '0;
        repeat (3) cyc();
        chk("rst_mem_req", bus.mem_req, 0);
        chk("rst_dl_idle", bus.dl_idle, 1);
        chk("rst_cart_valid", bus.cart_valid, 0);
        chk("rst_overflow", bus.dl_overflow, 0);
        chk("rst_mem_addr", bus.mem_addr, 0);
        chk("rst_cart_d", bus.cart_d, 0);
        reset = 0;
        repeat (2) cyc();

        // single read, ack 3 cycles after request
        lat_min = 3; lat_max = 3; force_rdata = 8'hA5;
        base = log_q.size();
        bus.cart_rd = 1; bus.cart_a = 20'h01234;
        cyc();
        bus.cart_rd = 0;
        chk("t2_no_req_decide", bus.mem_req, 0);
        cyc();
        chk("t2_req_issue", bus.mem_req, 1);
        repeat (3) cyc();
        chk("t2_req_until_ack", bus.mem_req, 1);
        cyc();
        chk("t2_valid", bus.cart_valid, 1);
        chk("t2_cart_d", bus.cart_d, 8'hA5);
        drain("t2", 100);
        chk("t2_count", log_q.size() - base, 1);
        o = log_q[base];
        chk("t2_we", o.we, 0);
        chk("t2_addr", o.addr, 25'h0001234);
        force_rdata = -1;

        // 8 consecutive writes, ack latency 4
        lat_min = 4; lat_max = 4;
        bus.dl_active = 1;
        base = log_q.size();
        for (int i = 0; i < 8; i++) begin
            t_addr[i] = ADDR_W'($urandom);
            t_data[i] = 8'($urandom);
            bus.dl_wr = 1; bus.dl_addr = t_addr[i]; bus.dl_data = t_data[i];
            cyc();
        end
        drain("t3", 500);
        chk("t3_count", log_q.size() - base, 8);
        for (int i = 0; i < 8; i++) begin
            o = log_q[base + i];
            chk("t3_we", o.we, 1);
            chk("t3_addr", o.addr, t_addr[i]);
            chk("t3_data", o.data, t_data[i]);
        end
        chk("t3_overflow", bus.dl_overflow, 0);
        chk("t3_idle", bus.dl_idle, 1);

        // 10 writes against a slow SDRAM overflow the FIFO
        lat_min = 20; lat_max = 20;
        base = log_q.size();
        for (int i = 0; i < 10; i++) begin
            bus.dl_wr = 1; bus.dl_addr = ADDR_W'(25'h100 + i); bus.dl_data = 8'(i);
            cyc();
        end
        bus.dl_wr = 0;
        chk("t4_overflow_set", bus.dl_overflow, 1);
        drain("t4", 2000);
        chk("t4_count", log_q.size() - base, 9);
        chk("t4_overflow_sticky", bus.dl_overflow, 1);
        bus.dl_active = 0;
        cyc();
        chk("t4_overflow_fall", bus.dl_overflow, 1);
        bus.dl_active = 1;
        cyc();
        chk("t4_overflow_clear", bus.dl_overflow, 0);

        // burst limit forces the pending read in after 4 writes
        lat_min = 2; lat_max = 2;
        base = log_q.size();
        bus.cart_rd = 1; bus.cart_a = 20'h0ABCD;
        wr_strobe(25'h200, 8'h00);
        bus.cart_rd = 0;
        for (int i = 1; i < 8; i++) wr_strobe(ADDR_W'(25'h200 + i), 8'(i));
        drain("t5", 500);
        chk("t5_count", log_q.size() - base, 9);
        seq = '0;
        for (int i = 0; i < 9 && base + i < log_q.size(); i++) seq[8-i] = log_q[base + i].we;
        chk("t5_sequence", seq, 9'b111101111);

        // coalesced reads, then a read requested while one is in flight
        lat_min = 3; lat_max = 3;
        base = log_q.size();
        bus.cart_rd = 1; bus.cart_a = 20'h00010;
        cyc();
        bus.cart_a = 20'h00020;
        cyc();
        bus.cart_rd = 0;
        cyc();
        bus.cart_rd = 1; bus.cart_a = 20'h00030;
        cyc();
        bus.cart_rd = 0;
        drain("t6", 200);
        chk("t6_count", log_q.size() - base, 2);
        if (log_q.size() - base >= 2) begin
            chk("t6_first_addr", log_q[base].addr, 25'h20);
            chk("t6_first_we", log_q[base].we, 0);
            chk("t6_second_addr", log_q[base + 1].addr, 25'h30);
            chk("t6_second_we", log_q[base + 1].we, 0);
        end

        // reset in the middle of a read, then a stray ack
        auto_ack = 0;
        bus.cart_rd = 1; bus.cart_a = 20'h00055;
        cyc();
        bus.cart_rd = 0;
        cyc();
        chk("t1_req_before_reset", bus.mem_req, 1);
        #2 reset = 1;
        cyc();
        reset = 0;
        chk("t1_req_after_reset", bus.mem_req, 0);
        chk("t1_valid_after_reset", bus.cart_valid, 0);
        chk("t1_idle_after_reset", bus.dl_idle, 1);
        late_ack_req = 1;
        cyc();
        chk("t1_late_ack_driven", bus.mem_ack, 1);
        cyc();
        chk("t1_req_ignored", bus.mem_req, 0);
        chk("t1_valid_ignored", bus.cart_valid, 0);
        cyc();
        chk("t1_valid_ignored2", bus.cart_valid, 0);
        auto_ack = 1;

        // randomized traffic
        lat_min = 0; lat_max = 5;
        for (int i = 0; i < 3000; i++) begin
            bus.dl_wr   = ($urandom_range(99, 0) < 40);
            bus.dl_addr = ADDR_W'($urandom);
            bus.dl_data = 8'($urandom);
            bus.cart_rd = ($urandom_range(99, 0) < 10);
            bus.cart_a  = 20'($urandom);
            if ($urandom_range(99, 0) < 2) bus.dl_active = ~bus.dl_active;
            cyc();
        end
        drain("rand", 2000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
